// File: rtl/one_bit_full_adder_pkg.sv
// Shared constants and bit-level arithmetic helpers for the one-bit full adder.
package one_bit_full_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/one_bit_full_adder_cell.sv
// Purely combinational one-bit full adder leaf (module full_adder_cell).
module full_adder_cell
    import one_bit_full_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = fa_sum(a, b, cin);
    assign cout = fa_carry(a, b, cin);

endmodule

// File: rtl/one_bit_full_adder.sv
// One-bit full adder with registered outputs; define ONE_BIT_FULL_ADDER_SERIAL_EN
// to add LSB-first bit-serial word accumulation (start/sum_word/carry_final/done).
module one_bit_full_adder
    import one_bit_full_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             X,
    input  logic             Y,
    input  logic             carryIn,
    output logic             Z,
    output logic             carryOut,
    input  logic             in_valid,
    output logic             out_valid,
    output logic             Z_q,
    output logic             carryOut_q
`ifdef ONE_BIT_FULL_ADDER_SERIAL_EN
    ,
    input  logic             start,
    output logic [WIDTH-1:0] sum_word,
    output logic             carry_final,
    output logic             done
`endif
);

    if (WIDTH < 2) begin : g_width_check
        $error("one_bit_full_adder: WIDTH must be at least 2");
    end

    full_adder_cell u_comb_cell (
        .a    (X),
        .b    (Y),
        .cin  (carryIn),
        .s    (Z),
        .cout (carryOut)
    );

    logic reg_z_d, reg_z_q;
    logic reg_cout_d, reg_cout_q;
    logic out_valid_d, out_valid_q;

    // NOTE: always_comb assigns every output a default first so no latch is inferred.
    always_comb begin
        reg_z_d     = reg_z_q;
        reg_cout_d  = reg_cout_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            reg_z_d    = Z;
            reg_cout_d = carryOut;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_z_q     <= 1'b0;
            reg_cout_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            reg_z_q     <= reg_z_d;
            reg_cout_q  <= reg_cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign Z_q        = reg_z_q;
    assign carryOut_q = reg_cout_q;
    assign out_valid  = out_valid_q;

`ifdef ONE_BIT_FULL_ADDER_SERIAL_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             ser_cin, ser_sum, ser_cout;
    logic [WIDTH-1:0] shift_d, shift_q;
    logic             carry_d, carry_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [WIDTH-1:0] sum_word_d, sum_word_q;
    logic             carry_final_d, carry_final_q;
    logic             done_d, done_q;

    assign ser_cin = start ? carryIn : carry_q;

    full_adder_cell u_serial_cell (
        .a    (X),
        .b    (Y),
        .cin  (ser_cin),
        .s    (ser_sum),
        .cout (ser_cout)
    );

    // bit_cnt == 0 means idle: only a start beat opens a new word.
    always_comb begin
        shift_d       = shift_q;
        carry_d       = carry_q;
        cnt_d         = cnt_q;
        sum_word_d    = sum_word_q;
        carry_final_d = carry_final_q;
        done_d        = 1'b0;
        if (in_valid && (start || cnt_q != '0)) begin
            shift_d = {ser_sum, shift_q[WIDTH-1:1]};
            carry_d = ser_cout;
            cnt_d   = start ? CNT_W'(1) : cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(WIDTH)) begin
                sum_word_d    = shift_d;
                carry_final_d = carry_d;
                done_d        = 1'b1;
                cnt_d         = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q       <= 1'b0;
            cnt_q         <= '0;
            sum_word_q    <= '0;
            carry_final_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            carry_q       <= carry_d;
            cnt_q         <= cnt_d;
            sum_word_q    <= sum_word_d;
            carry_final_q <= carry_final_d;
            done_q        <= done_d;
        end
    end

    // NOTE: the shift register is left unreset; a word is only published after all WIDTH bits are overwritten.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign sum_word    = sum_word_q;
    assign carry_final = carry_final_q;
    assign done        = done_q;
`endif

endmodule

// File: tb/tb_one_bit_full_adder.sv
// Directed self-checking bench for one_bit_full_adder; serial-mode steps run
// only when ONE_BIT_FULL_ADDER_SERIAL_EN is defined.
module tb_one_bit_full_adder;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst = 1'b0;
    logic X = 1'b0, Y = 1'b0, carryIn = 1'b0, in_valid = 1'b0;
    logic Z, carryOut, out_valid, Z_q, carryOut_q;
    logic start = 1'b0;
    logic [WIDTH-1:0] sum_word;
    logic carry_final, done;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 if (clk_en) clk = ~clk;

    one_bit_full_adder #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .X          (X),
        .Y          (Y),
        .carryIn    (carryIn),
        .Z          (Z),
        .carryOut   (carryOut),
        .in_valid   (in_valid),
        .out_valid  (out_valid),
        .Z_q        (Z_q),
        .carryOut_q (carryOut_q)
`ifdef ONE_BIT_FULL_ADDER_SERIAL_EN
        ,
        .start       (start),
        .sum_word    (sum_word),
        .carry_final (carry_final),
        .done        (done)
`endif
    );

`ifndef ONE_BIT_FULL_ADDER_SERIAL_EN
    assign sum_word    = '0;
    assign carry_final = 1'b0;
    assign done        = 1'b0;
`endif

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 ns after the following rising edge.
    task automatic beat(input logic vx, input logic vy, input logic vc,
                        input logic vv, input logic vs);
        @(negedge clk);
        X = vx; Y = vy; carryIn = vc; in_valid = vv; start = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic cin0, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            beat(a[i], b[i], (i == 0) ? cin0 : 1'b0, 1'b1, i == 0);
            check($sformatf("%s_done_b%0d", tag, i), 16'(done), 16'(i == WIDTH - 1));
        end
        @(negedge clk);
        in_valid = 1'b0; start = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_z;
        logic [7:0] exp_c;
        logic [2:0] v;
        // Truth table indexed by {X,Y,cin}: Z set for 001,010,100,111; carry for 011,101,110,111.
        exp_z = 8'b1001_0110;
        exp_c = 8'b1110_1000;

        #1 rst = 1'b1;
        #1;
        check("rst_Z_q", 16'(Z_q), 16'h0);
        check("rst_carryOut_q", 16'(carryOut_q), 16'h0);
        check("rst_out_valid", 16'(out_valid), 16'h0);
        check("rst_sum_word", 16'(sum_word), 16'h0);
        check("rst_carry_final", 16'(carry_final), 16'h0);
        check("rst_done", 16'(done), 16'h0);

        // Combinational sweep with no clock running and reset held.
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            X = v[2]; Y = v[1]; carryIn = v[0];
            #10;
            check($sformatf("comb_Z_%03b", v), 16'(Z), 16'(exp_z[i]));
            check($sformatf("comb_cout_%03b", v), 16'(carryOut), 16'(exp_c[i]));
        end
        check("rst_holds_Z_q", 16'(Z_q), 16'h0);

        rst = 1'b0;
        clk_en = 1'b1;

        beat(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("reg111_Z_q", 16'(Z_q), 16'h1);
        check("reg111_carryOut_q", 16'(carryOut_q), 16'h1);
        check("reg111_out_valid", 16'(out_valid), 16'h1);
        beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("hold_Z_q", 16'(Z_q), 16'h1);
        check("hold_carryOut_q", 16'(carryOut_q), 16'h1);
        check("hold_out_valid", 16'(out_valid), 16'h0);
        beat(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("reg100_Z_q", 16'(Z_q), 16'h1);
        check("reg100_carryOut_q", 16'(carryOut_q), 16'h0);
        beat(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("reg011_Z_q", 16'(Z_q), 16'h0);
        check("reg011_carryOut_q", 16'(carryOut_q), 16'h1);
        beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef ONE_BIT_FULL_ADDER_SERIAL_EN
        // 0x5A + 0x3C = 0x096
        send_word("w1", 8'h5A, 8'h3C, 1'b0, 8);
        check("w1_sum_word", 16'(sum_word), 16'h0096);
        check("w1_carry_final", 16'(carry_final), 16'h0);
        beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("w1_done_pulse_end", 16'(done), 16'h0);
        check("w1_sum_holds", 16'(sum_word), 16'h0096);

        // 0xFF + 0x00 + 1 = 0x100
        send_word("w2", 8'hFF, 8'h00, 1'b1, 8);
        check("w2_sum_word", 16'(sum_word), 16'h0000);
        check("w2_carry_final", 16'(carry_final), 16'h1);

        // Reset after beat 4 aborts the word and clears every registered output.
        send_word("w3", 8'h12, 8'h34, 1'b0, 4);
        rst = 1'b1;
        #2;
        check("midrst_sum_word", 16'(sum_word), 16'h0);
        check("midrst_carry_final", 16'(carry_final), 16'h0);
        check("midrst_done", 16'(done), 16'h0);
        check("midrst_Z_q", 16'(Z_q), 16'h0);
        check("midrst_carryOut_q", 16'(carryOut_q), 16'h0);
        check("midrst_out_valid", 16'(out_valid), 16'h0);
        rst = 1'b0;
        // Non-start beats while idle must not complete a word.
        for (int i = 0; i < WIDTH; i++) begin
            beat(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            check($sformatf("idle_done_b%0d", i), 16'(done), 16'h0);
        end
        check("idle_sum_word", 16'(sum_word), 16'h0);
        // 0x0F + 0x01 = 0x010
        send_word("w4", 8'h0F, 8'h01, 1'b0, 8);
        check("w4_sum_word", 16'(sum_word), 16'h0010);
        check("w4_carry_final", 16'(carry_final), 16'h0);

        // Five beats of an aborted word, then a fresh start: 0xF0 + 0x20 = 0x110.
        send_word("w5", 8'hAA, 8'h55, 1'b0, 5);
        check("abort_sum_holds", 16'(sum_word), 16'h0010);
        send_word("w6", 8'hF0, 8'h20, 1'b0, 8);
        check("w6_sum_word", 16'(sum_word), 16'h0010);
        check("w6_carry_final", 16'(carry_final), 16'h1);

        // Restart mid-word with no idle gap: 0x33 + 0x44 = 0x077.
        for (int i = 0; i < 5; i++) begin
            beat(1'b1, 1'b0, 1'b0, 1'b1, i == 0);
        end
        send_word("w7", 8'h33, 8'h44, 1'b0, 8);
        check("w7_sum_word", 16'(sum_word), 16'h0077);
        check("w7_carry_final", 16'(carry_final), 16'h0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
